// File: rtl/vga_frame_capture.sv
// VGA link receiver: synchronises rgb/h_sync/v_sync and writes one frame into a 64K x 3 frame RAM.
// Optional line-length checker enabled by defining VGA_CAP_TIMING_CHECK_EN.
module vga_frame_capture #(
  parameter int   H_BACK   = 48,
  parameter int   H_ACTIVE = 256,
  parameter int   H_TOTAL  = 400,
  parameter int   V_BACK   = 33,
  parameter int   V_ACTIVE = 480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  rgb_in,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        capture_en,
  output logic        wr_ena,
  output logic [15:0] addr,
  output logic [2:0]  data,
  output logic        frame_done,
  output logic        busy,
  output logic        timing_err
);

  localparam int HW = $clog2(H_BACK + H_ACTIVE + 1);
  localparam logic [HW-1:0] PIX_START = HW'(H_BACK);
  localparam logic [HW-1:0] PIX_END   = HW'(H_BACK + H_ACTIVE);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_VBACK, S_ACTIVE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [8:0]    line_q, line_d;
  logic [HW-1:0] hcnt_q, hcnt_d, hpos;
  logic [2:0]    rgb1_q, rgb2_q;
  logic          hs1_q, hs2_q, hs3_q;
  logic          vs1_q, vs2_q, vs3_q;
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [2:0]    data_q;
  logic          h_deassert, v_deassert, in_window, line_err;
  logic [7:0]    pix;

  // hs3/vs3 hold the previous synchronised sample so edges see equal delay on all three inputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb1_q <= '0;
      rgb2_q <= '0;
      hs1_q  <= ~SYNC_POL;
      hs2_q  <= ~SYNC_POL;
      hs3_q  <= ~SYNC_POL;
      vs1_q  <= ~SYNC_POL;
      vs2_q  <= ~SYNC_POL;
      vs3_q  <= ~SYNC_POL;
    end else begin
      rgb1_q <= rgb_in;
      rgb2_q <= rgb1_q;
      hs1_q  <= h_sync;
      hs2_q  <= hs1_q;
      hs3_q  <= hs2_q;
      vs1_q  <= v_sync;
      vs2_q  <= vs1_q;
      vs3_q  <= vs2_q;
    end
  end

  assign h_deassert = (hs3_q == SYNC_POL) && (hs2_q != SYNC_POL);
  assign v_deassert = (vs3_q == SYNC_POL) && (vs2_q != SYNC_POL);

  // hpos = clocks since the last h_sync deassert edge, saturating just past the active window
  always_comb begin
    hpos   = h_deassert ? '0 : hcnt_q;
    hcnt_d = hcnt_q;
    if (h_deassert)
      hcnt_d = HW'(1);
    else if (hcnt_q != PIX_END)
      hcnt_d = hcnt_q + HW'(1);
  end

  assign in_window = (hpos >= PIX_START) && (hpos < PIX_END);
  assign pix       = 8'(hpos - PIX_START);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        if (capture_en) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!capture_en) begin
          state_d = S_IDLE;
        end else if (v_deassert) begin
          state_d = S_VBACK;
          line_d  = '0;
        end
      end
      S_VBACK: begin
        if (v_deassert) begin
          line_d = '0;
        end else if (h_deassert) begin
          if (line_q == 9'(V_BACK - 1)) begin
            state_d = S_ACTIVE;
            line_d  = '0;
          end else begin
            line_d = line_q + 9'd1;
          end
        end
      end
      S_ACTIVE: begin
        if (v_deassert) begin
          state_d = S_VBACK;
          line_d  = '0;
        end else if (h_deassert) begin
          if (line_q == 9'(V_ACTIVE - 1)) state_d = S_DONE;
          else                            line_d  = line_q + 9'd1;
        end
      end
      S_DONE: begin
        line_d  = '0;
        state_d = capture_en ? S_ARMED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (line_err) begin
      state_d = S_ARMED;
      line_d  = '0;
    end
  end

  // odd lines duplicate the even line above them, so only even lines are stored
  assign wr_d   = (state_q == S_ACTIVE) && in_window && !line_q[0];
  assign addr_d = {line_q[8:1], pix};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      hcnt_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      hcnt_q  <= hcnt_d;
      wr_q    <= wr_d;
      addr_q  <= wr_d ? addr_d : addr_q;
      data_q  <= wr_d ? rgb2_q : data_q;
    end
  end

  assign wr_ena     = wr_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign frame_done = (state_q == S_DONE);
  assign busy       = (state_q == S_VBACK) || (state_q == S_ACTIVE);

`ifdef VGA_CAP_TIMING_CHECK_EN
  localparam int LW = $clog2(H_TOTAL + 2);

  logic [LW-1:0] lcnt_q;
  logic          seen_q, err_q, capen_prev_q, h_assert;

  assign h_assert = (hs3_q != SYNC_POL) && (hs2_q == SYNC_POL);
  // only a line bounded by two assert edges inside the frame is measured
  assign line_err = busy && h_assert && seen_q && (lcnt_q != LW'(H_TOTAL));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lcnt_q       <= '0;
      seen_q       <= 1'b0;
      err_q        <= 1'b0;
      capen_prev_q <= 1'b0;
    end else begin
      capen_prev_q <= capture_en;
      if (h_assert)
        lcnt_q <= LW'(1);
      else if (lcnt_q != {LW{1'b1}})
        lcnt_q <= lcnt_q + LW'(1);
      if (!busy || line_err)
        seen_q <= 1'b0;
      else if (h_assert)
        seen_q <= 1'b1;
      if (line_err)
        err_q <= 1'b1;
      else if (capture_en && !capen_prev_q)
        err_q <= 1'b0;
    end
  end

  assign timing_err = err_q;
`else
  assign line_err   = 1'b0;
  assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Randomised bench for vga_frame_capture: a line/frame generator predicts every RAM write and frame_done.
module tb_vga_frame_capture;
  localparam int H_BACK   = 4;
  localparam int H_ACTIVE = 16;
  localparam int H_TOTAL  = 32;
  localparam int V_BACK   = 3;
  localparam int V_ACTIVE = 10;
  localparam int HS_W     = 4;
  localparam int PIX0     = HS_W + H_BACK;
  localparam int FULL_WR  = (V_ACTIVE / 2) * H_ACTIVE;
  localparam logic [15:0] MAX_ADDR = {8'(V_ACTIVE / 2 - 1), 8'(H_ACTIVE - 1)};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  rgb_in = '0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic        capture_en = 1'b0;
  logic        wr_ena, frame_done, busy, timing_err;
  logic [15:0] addr;
  logic [2:0]  data;

  vga_frame_capture #(
    .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in), .h_sync(h_sync), .v_sync(v_sync),
    .capture_en(capture_en), .wr_ena(wr_ena), .addr(addr), .data(data),
    .frame_done(frame_done), .busy(busy), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          it;
    logic [15:0] a;
    logic [2:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  int          done_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          iter = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] first_addr = '0;
  logic [15:0] last_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (iter %0d)", tag, got, exp, iter);
    end
  endtask

  // one clock: sample outputs at negedge against the predicted streams, then drive the pins
  task automatic tick(input logic [2:0] r, input logic hs, input logic vs);
    @(negedge clk);
    iter++;
    if (wr_ena === 1'b1) begin
      if (wr_cnt == 0) first_addr = addr;
      wr_cnt++;
      last_addr = addr;
      if (exp_q.size() > 0 && exp_q[0].it == iter) begin
        check_eq("wr_addr", 32'(addr), 32'(exp_q[0].a));
        check_eq("wr_data", 32'(data), 32'(exp_q[0].d));
        void'(exp_q.pop_front());
      end else begin
        check_eq("wr_unexpected", 32'(wr_ena), 32'd0);
      end
    end else if (exp_q.size() > 0 && exp_q[0].it == iter) begin
      check_eq("wr_missing", 32'(wr_ena), 32'd1);
      void'(exp_q.pop_front());
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (done_q.size() > 0 && done_q[0] == iter) begin
        check_eq("frame_done", 32'(frame_done), 32'd1);
        void'(done_q.pop_front());
      end else begin
        check_eq("done_unexpected", 32'(frame_done), 32'd0);
      end
    end else if (done_q.size() > 0 && done_q[0] == iter) begin
      check_eq("done_missing", 32'(frame_done), 32'd1);
      void'(done_q.pop_front());
    end
    rgb_in = r;
    h_sync = hs;
    v_sync = vs;
  endtask

  function automatic logic [2:0] pix_rgb(input int mode, input int n, input int p);
    if (mode == 0) return 3'(p);
    if (mode == 1) return (n % 2 == 1) ? 3'b111 : 3'b000;
    return 3'($urandom);
  endfunction

  // n >= 0 is the active line index; a value driven now shows up on the outputs 3 ticks later
  task automatic send_line(input int n, input bit vp, input bit exp_wr, input bit done_edge,
                           input int mode, input int len);
    logic       hs, vs;
    logic [2:0] r;
    int         p;
    wr_t        e;
    for (int off = 0; off < len; off++) begin
      hs = (off < HS_W) ? 1'b0 : 1'b1;
      vs = (vp && off >= 26 && off < 30) ? 1'b0 : 1'b1;
      p  = off - PIX0;
      if (n >= 0 && p >= 0 && p < H_ACTIVE) r = pix_rgb(mode, n, p);
      else                                  r = 3'($urandom);
      if (exp_wr && n >= 0 && n % 2 == 0 && p >= 0 && p < H_ACTIVE) begin
        e.it = iter + 4;
        e.a  = {8'(n / 2), 8'(p)};
        e.d  = r;
        exp_q.push_back(e);
      end
      if (done_edge && off == HS_W) done_q.push_back(iter + 4);
      if (exp_wr && n >= 0 && off == H_TOTAL / 2) check_eq("busy_active", 32'(busy), 32'd1);
      tick(r, hs, vs);
    end
  endtask

  task automatic gap(input int cycles);
    for (int i = 0; i < cycles; i++) tick(3'($urandom), 1'b1, 1'b1);
  endtask

  task automatic start_frame(input int mode);
    gap($urandom_range(3, 10));
    check_eq("busy_idle", 32'(busy), 32'd0);
    send_line(-1, 1'b1, 1'b0, 1'b0, mode, H_TOTAL);
  endtask

  task automatic frame_body(input int mode, input bit cap, input int abort_at,
                            input int drop_at, input int short_at);
    wr_cnt   = 0;
    done_cnt = 0;
    for (int k = 1; k < V_BACK; k++) send_line(-1, 1'b0, 1'b0, 1'b0, mode, H_TOTAL);
    for (int n = 0; n < V_ACTIVE; n++) begin
      if (n == drop_at) capture_en = 1'b0;
      if (short_at >= 0 && n == short_at + 1) begin
        send_line(-1, 1'b0, 1'b0, 1'b0, mode, H_TOTAL);
        return;
      end
      send_line(n, n == abort_at, cap, 1'b0, mode, (n == short_at) ? H_TOTAL - 1 : H_TOTAL);
      if (n == abort_at) return;
    end
    send_line(-1, 1'b0, 1'b0, cap, mode, H_TOTAL);
  endtask

  task automatic report_frame(input string name, input int exp_wr, input int exp_done);
    check_eq({name, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
    check_eq({name, "_done"}, 32'(done_cnt), 32'(exp_done));
    if (exp_wr == FULL_WR) begin
      check_eq({name, "_first"}, 32'(first_addr), 32'h0);
      check_eq({name, "_last"}, 32'(last_addr), 32'(MAX_ADDR));
    end
    $display("[TB] frame %s: writes=%0d done=%0d last_addr=%04h", name, wr_cnt, done_cnt, last_addr);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      capture_en = 1'($urandom);
      tick(3'($urandom), 1'($urandom), 1'($urandom));
      check_eq("reset_out", 32'({wr_ena, addr, data, frame_done, busy, timing_err}), 32'd0);
    end
    capture_en = 1'b0;
    reset_n    = 1'b1;

    start_frame(2);
    frame_body(2, 1'b0, -1, -1, -1);
    report_frame("disabled", 0, 0);

    capture_en = 1'b1;
    start_frame(0);
    frame_body(0, 1'b1, -1, -1, -1);
    report_frame("pixramp", FULL_WR, 1);

    start_frame(1);
    frame_body(1, 1'b1, -1, -1, -1);
    report_frame("oddwhite", FULL_WR, 1);

    start_frame(2);
    frame_body(2, 1'b1, 4, -1, -1);
    report_frame("aborted", 3 * H_ACTIVE, 0);
    frame_body(2, 1'b1, -1, -1, -1);
    report_frame("restart", FULL_WR, 1);

    start_frame(2);
    frame_body(2, 1'b1, -1, 6, -1);
    report_frame("en_drop", FULL_WR, 1);
    start_frame(2);
    frame_body(2, 1'b0, -1, -1, -1);
    report_frame("after_drop", 0, 0);

    capture_en = 1'b1;
    start_frame(2);
    frame_body(2, 1'b1, -1, -1, -1);
    report_frame("random", FULL_WR, 1);

`ifdef VGA_CAP_TIMING_CHECK_EN
    start_frame(2);
    frame_body(2, 1'b1, -1, -1, 2);
    gap(4);
    report_frame("short_line", 2 * H_ACTIVE, 0);
    check_eq("timing_err_set", 32'(timing_err), 32'd1);
    capture_en = 1'b0;
    gap(2);
    capture_en = 1'b1;
    gap(3);
    check_eq("timing_err_clr", 32'(timing_err), 32'd0);
`else
    check_eq("timing_err_off", 32'(timing_err), 32'd0);
`endif

    gap(8);
    check_eq("exp_writes_left", 32'(exp_q.size()), 32'd0);
    check_eq("exp_done_left", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
